fetch_prefetch_unit: RTL

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register of the 8-bit pipelined core. It owns the PC and issues sequential reads to the 16x8 synchronous instruction memory. Returned bytes are buffered, each tagged with its PC, in a small prefetch FIFO. Decode consumes them over a valid/ready handshake, and a branch redirect from EX flushes all buffered and in-flight fetches.

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_prefetch_unit.sv | 75 +++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath widths,
// the bubble encoding and the fetch entry type carried by the prefetch FIFO.
package core_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] NOP_INSTR = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO of {pc, instr} entries with synchronous flush.
// The head is a register, so it holds its last value while the FIFO is empty.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign rd_next = rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '{pc: '0, instr: NOP_INSTR};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_next;
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head register tracks whichever entry sits at the read pointer after this edge.
      if (push && (count == '0))
        head <= push_data;
      else if (do_pop) begin
        if (count > CW'(1))
          head <= mem[rd_next];
        else if (push)
          head <= push_data;
      end
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential reads to the
// synchronous instruction memory and buffers returned bytes for decode.
module fetch_prefetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic [CW-1:0]     fifo_count
);

  logic [ADDR_W-1:0]     pc;
  logic [ADDR_W-1:0]     tag;
  logic                  inflight;
  logic                  kill;
  logic [CW:0]           occ;
  logic                  push;
  logic                  pop;
  core_pkg::fetch_entry_t push_data;
  core_pkg::fetch_entry_t head;

  // Credit check ignores a same-cycle pop, so a slot is always free for the response.
  assign occ      = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign imem_req = !reset && !redirect_valid && (occ < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign push      = inflight && !kill;
  assign pop       = out_valid && out_ready;
  assign push_data = '{pc: tag, instr: imem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      kill     <= redirect_valid && inflight;
      inflight <= imem_req;
      if (redirect_valid)
        pc <= redirect_pc;
      else if (imem_req) begin
        pc  <= pc + ADDR_W'(1);
        tag <= pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
